// File: rtl/serial_paralelo_param.sv
// serial_paralelo_param: bit-clock serial-to-parallel receiver that hunts for COMMA, locks the word boundary
// to it and delivers WIDTH-bit words. Optional macro SERPAR_RELOCK_EN adds off-phase comma re-search.
module serial_paralelo_param #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] COMMA        = 8'hBC,
  parameter int               LOCK_COUNT   = 4,
  parameter int               RELOCK_COUNT = 3
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic             aligned,
  output logic             word_strobe
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       LOCK_C = 4'(LOCK_COUNT);

  if (WIDTH < 4 || WIDTH > 16 || LOCK_COUNT < 1 || LOCK_COUNT > 15 ||
      RELOCK_COUNT < 1 || RELOCK_COUNT > 15) begin : g_bad_params
    $error("serial_paralelo_param: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_ALIGNED = 2'd1,
    S_ACTIVE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [3:0]       r_comma_cnt;
  logic             r_valid;
  logic             r_active;
  logic             r_aligned;
  logic             r_strobe;

  logic [WIDTH-1:0] w_shreg_next;
  logic             w_is_comma;
  logic             w_boundary;
  logic [CNT_W-1:0] w_bit_cnt_inc;
  logic [3:0]       w_comma_inc;

  assign w_shreg_next  = {r_shreg[WIDTH-2:0], data_in};
  assign w_is_comma    = (w_shreg_next == COMMA);
  assign w_boundary    = (r_bit_cnt == LAST);
  assign w_bit_cnt_inc = w_boundary ? '0 : r_bit_cnt + CNT_W'(1);
  assign w_comma_inc   = (r_comma_cnt == 4'hF) ? r_comma_cnt : r_comma_cnt + 4'd1;

`ifdef SERPAR_RELOCK_EN
  localparam logic [3:0] RELOCK_C = 4'(RELOCK_COUNT);

  logic             r_off_seen;
  logic [CNT_W-1:0] r_off_phase;
  logic [CNT_W-1:0] r_prev_phase;
  logic [3:0]       r_relock_cnt;
  logic [3:0]       w_relock_next;
  logic             w_relock;

  // A window only extends the run if its off-phase comma sits where the previous window's did.
  always_comb begin
    w_relock_next = 4'd0;
    if (!w_is_comma && r_off_seen &&
        (r_relock_cnt == 4'd0 || r_off_phase == r_prev_phase)) begin
      w_relock_next = (r_relock_cnt == 4'hF) ? r_relock_cnt : r_relock_cnt + 4'd1;
    end
  end

  assign w_relock = (r_state == S_ACTIVE) && w_boundary && (w_relock_next >= RELOCK_C);
`endif

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state     <= S_SEARCH;
      r_shreg     <= '0;
      r_data      <= '0;
      r_bit_cnt   <= '0;
      r_comma_cnt <= 4'd0;
      r_valid     <= 1'b0;
      r_active    <= 1'b0;
      r_aligned   <= 1'b0;
      r_strobe    <= 1'b0;
`ifdef SERPAR_RELOCK_EN
      r_off_seen   <= 1'b0;
      r_off_phase  <= '0;
      r_prev_phase <= '0;
      r_relock_cnt <= 4'd0;
`endif
    end else begin
      r_shreg  <= w_shreg_next;
      r_strobe <= 1'b0;
      case (r_state)
        S_SEARCH: begin
          if (w_is_comma) begin
            r_bit_cnt   <= '0;
            r_comma_cnt <= 4'd1;
            r_aligned   <= 1'b1;
            if (LOCK_COUNT == 1) begin
              r_state  <= S_ACTIVE;
              r_active <= 1'b1;
            end else begin
              r_state <= S_ALIGNED;
            end
          end
        end

        S_ALIGNED: begin
          r_bit_cnt <= w_bit_cnt_inc;
          if (w_boundary) begin
            r_strobe <= 1'b1;
            if (w_is_comma) begin
              r_comma_cnt <= w_comma_inc;
              if (w_comma_inc >= LOCK_C) begin
                r_state  <= S_ACTIVE;
                r_active <= 1'b1;
              end
            end else begin
              // Hunting restarts on the next bit, not on this rejected boundary.
              r_state     <= S_SEARCH;
              r_comma_cnt <= 4'd0;
              r_aligned   <= 1'b0;
            end
          end
        end

        S_ACTIVE: begin
          r_bit_cnt <= w_bit_cnt_inc;
`ifdef SERPAR_RELOCK_EN
          if (!w_boundary && w_is_comma && !r_off_seen) begin
            r_off_seen  <= 1'b1;
            r_off_phase <= r_bit_cnt;
          end
`endif
          if (w_boundary) begin
            r_strobe <= 1'b1;
`ifdef SERPAR_RELOCK_EN
            r_off_seen   <= 1'b0;
            r_prev_phase <= r_off_phase;
            r_relock_cnt <= w_relock_next;
            if (w_relock) begin
              r_state      <= S_SEARCH;
              r_active     <= 1'b0;
              r_aligned    <= 1'b0;
              r_valid      <= 1'b0;
              r_comma_cnt  <= 4'd0;
              r_relock_cnt <= 4'd0;
            end else
`endif
            if (!w_is_comma) begin
              r_data  <= w_shreg_next;
              r_valid <= 1'b1;
            end else begin
              r_valid <= 1'b0;
            end
          end
        end

        default: r_state <= S_SEARCH;
      endcase
    end
  end

  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign active      = r_active;
  assign aligned     = r_aligned;
  assign word_strobe = r_strobe;

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Bench for serial_paralelo_param: random and directed serial streams against a word-level reference model,
// word-strobe scoreboard plus per-cycle state comparison.
module tb_serial_paralelo_param;

  localparam int         W      = 8;
  localparam logic [7:0] COMMA  = 8'hBC;
  localparam int         LOCK   = 4;
  localparam int         RELOCK = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic [W-1:0] dout;
  logic         valid, act, aln, strb;

  always #5 clk = ~clk;

  serial_paralelo_param #(
    .WIDTH(W), .COMMA(COMMA), .LOCK_COUNT(LOCK), .RELOCK_COUNT(RELOCK)
  ) dut (
    .clk_32f(clk), .reset(rst), .data_in(din), .data_out(dout),
    .valid_out(valid), .active(act), .aligned(aln), .word_strobe(strb)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef logic [W+2:0] exp_t;  // {active, aligned, valid, data}
  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model: tracks the last W received bits and the bit position inside the locked word.
  int           m_window, m_since, m_commas, m_rc, m_cur, m_prev;
  bit           m_locked;
  logic         m_act, m_aln, m_val;
  logic [W-1:0] m_data;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic void model_reset();
    m_window = 0; m_since = 0; m_commas = 0; m_rc = 0; m_cur = -1; m_prev = -1;
    m_locked = 1'b0; m_act = 1'b0; m_aln = 1'b0; m_val = 1'b0; m_data = '0;
    sb_q.delete();
  endfunction

  function automatic void model_step(logic b);
    bit relock = 1'b0;
    m_window = ((m_window << 1) | int'(b)) & ((1 << W) - 1);
    if (!m_locked) begin
      if (m_window == int'(COMMA)) begin
        m_locked = 1'b1; m_since = 0; m_commas = 1; m_aln = 1'b1;
        m_act = (LOCK == 1); m_rc = 0; m_cur = -1; m_prev = -1;
      end
    end else begin
      m_since++;
      if (m_since < W) begin
`ifdef SERPAR_RELOCK_EN
        if (m_act && m_window == int'(COMMA) && m_cur < 0) m_cur = m_since;
`endif
      end else begin
        m_since = 0;
        if (!m_act) begin
          if (m_window == int'(COMMA)) begin
            m_commas = (m_commas < 15) ? m_commas + 1 : 15;
            if (m_commas >= LOCK) m_act = 1'b1;
          end else begin
            m_locked = 1'b0; m_aln = 1'b0; m_commas = 0;
          end
        end else begin
`ifdef SERPAR_RELOCK_EN
          if (m_window == int'(COMMA)) m_rc = 0;
          else if (m_cur >= 0 && (m_rc == 0 || m_cur == m_prev)) m_rc = (m_rc < 15) ? m_rc + 1 : 15;
          else m_rc = 0;
          m_prev = m_cur; m_cur = -1;
          if (m_rc >= RELOCK) begin
            relock = 1'b1; m_locked = 1'b0; m_act = 1'b0; m_aln = 1'b0;
            m_val = 1'b0; m_commas = 0; m_rc = 0;
          end
`endif
          if (!relock) begin
            if (m_window != int'(COMMA)) begin
              m_data = m_window[W-1:0];
              m_val  = 1'b1;
            end else begin
              m_val = 1'b0;
            end
          end
        end
        sb_q.push_back({m_act, m_aln, m_val, m_data});
      end
    end
  endfunction

  // Monitor: every word strobe must match the next expected boundary result.
  always @(negedge clk) begin
    if (strb === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL strobe: unexpected word_strobe, data_out %0h at %0t", dout, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("word", {21'd0, act, aln, valid, dout}, {21'd0, mon_e});
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    check("state", {21'd0, act, aln, valid, dout}, {21'd0, m_act, m_aln, m_val, m_data});
    din = b;
    model_step(b);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_word(COMMA);
  endtask

  // Looks at the outputs just after the edge that consumes the last driven bit.
  task automatic peek(input string n, input logic ea, input logic ev, input logic [W-1:0] ed);
    @(posedge clk);
    #1;
    check(n, {21'd0, act, valid, dout}, {21'd0, ea, ev, ed});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", {20'd0, act, aln, valid, strb, dout}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] rw;
  logic         expect_act;

  initial begin
    model_reset();
    #2 check("reset_state", {20'd0, act, aln, valid, strb, dout}, 32'd0);
    #1 rst = 1'b0;

    // Aligned after the first comma, active at the fourth, then two data words.
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_commas(3);
    peek("lock_3rd_comma", 1'b0, 1'b0, 8'h00);
    send_commas(1);
    peek("lock_4th_comma", 1'b1, 1'b0, 8'h00);
    send_word(8'hFF);
    peek("first_word", 1'b1, 1'b1, 8'hFF);
    send_word(8'hEE);
    peek("second_word", 1'b1, 1'b1, 8'hEE);

    // Idle word between data holds data_out and drops valid.
    send_word(8'hA1);
    peek("pre_idle", 1'b1, 1'b1, 8'hA1);
    send_word(COMMA);
    peek("idle_hold", 1'b1, 1'b0, 8'hA1);
    send_word(8'hA2);
    peek("post_idle", 1'b1, 1'b1, 8'hA2);

    // Broken alignment run falls back to search, then relocks.
    pulse_reset();
    send_commas(2);
    send_word(8'h55);
    send_commas(4);
    send_word(8'h3C);
    peek("relock_word", 1'b1, 1'b1, 8'h3C);

    // Arbitrary bit phase.
    pulse_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(1)));
    send_commas(4);
    send_word(8'h12);
    peek("offset_word", 1'b1, 1'b1, 8'h12);

    // Reset in the middle of a word while active.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    pulse_reset();
    send_commas(3);
    send_word(COMMA);
    peek("post_reset_lock", 1'b1, 1'b0, 8'h00);
    send_word(8'h77);
    peek("post_reset_word", 1'b1, 1'b1, 8'h77);

    // Two-bit slip followed by commas at the new phase.
    send_bit(1'b0); send_bit(1'b0);
    send_commas(4);
`ifdef SERPAR_RELOCK_EN
    expect_act = 1'b0;
`else
    expect_act = 1'b1;
`endif
    @(posedge clk);
    #1 check("slip_active", {31'd0, act}, {31'd0, expect_act});
    send_commas(3);
`ifdef SERPAR_RELOCK_EN
    send_word(8'h5A);
    peek("slip_relock_word", 1'b1, 1'b1, 8'h5A);
`endif

    // Randomised traffic with occasional idles and bit slips.
    pulse_reset();
    for (int i = 0; i < int'($urandom_range(W - 1)); i++) send_bit(1'($urandom_range(1)));
    send_commas(LOCK);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(15) == 0) begin
        for (int s = 0; s < int'($urandom_range(3, 1)); s++) send_bit(1'($urandom_range(1)));
      end
      rw = ($urandom_range(3) == 0) ? COMMA : W'($urandom);
      send_word(rw);
    end

    @(negedge clk);
    @(negedge clk);
    check("pending_words", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
